// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx -- UART byte receiver with host-command decode.
//
// Receives 8N1 frames (or 8E1 when UART_PARITY_EN is defined) on an
// asynchronous serial line, presents each correctly framed byte, and
// decodes bytes of the form 2'b01_xxxxxx as a 6-bit host command index.
//
// Build option:
//   UART_PARITY_EN  -- one even-parity bit follows the data bits; a parity
//                      mismatch is reported on uart_frame_err and the byte
//                      is dropped.
//
// Parameters:
//   CLKS_PER_BIT    -- ex_clk cycles per UART bit (4..65535)
//
// Ports:
//   ex_clk          -- sole clock, rising edge
//   ex_resetn       -- asynchronous active-low reset
//   uart_rx         -- serial line, idles high, asynchronous to ex_clk
//   uart_rx_data    -- last correctly received byte
//   uart_rx_valid   -- one-cycle pulse when uart_rx_data updates
//   uart_cmd        -- command index from the last command byte
//   uart_cmd_en     -- one-cycle pulse when uart_cmd updates
//   uart_frame_err  -- one-cycle pulse on a bad stop (or parity) bit
//   uart_busy       -- high whenever the receiver is not idle
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       ex_clk,
  input  logic       ex_resetn,
  input  logic       uart_rx,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_valid,
  output logic [5:0] uart_cmd,
  output logic       uart_cmd_en,
  output logic       uart_frame_err,
  output logic       uart_busy
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BIT_HALF = 16'(CLKS_PER_BIT / 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
`ifdef UART_PARITY_EN
    ,
    PARITY = 3'd5
`endif
  } state_t;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  logic       rx_meta_r;
  logic       rx_sync_r;
  state_t     state_r;
  logic [15:0] cnt_r;
  logic [2:0] bit_idx_r;
  logic [7:0] shift_r;
  logic       load_pend_r;
  logic [7:0] data_r;
  logic       valid_r;
  logic [5:0] cmd_r;
  logic       cmd_en_r;
  logic       frame_err_r;
  logic       busy_r;
  logic       parity_bad_s;

`ifdef UART_PARITY_EN
  logic       parity_err_r;
  assign parity_bad_s = parity_err_r;
`else
  assign parity_bad_s = 1'b0;
`endif

  assign uart_rx_data   = data_r;
  assign uart_rx_valid  = valid_r;
  assign uart_cmd       = cmd_r;
  assign uart_cmd_en    = cmd_en_r;
  assign uart_frame_err = frame_err_r;
  assign uart_busy      = busy_r;

  // Two-flop synchronizer for the serial line; resets to the idle level.
  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Receive FSM plus registered output pulses and held data/command.
  always_ff @(posedge ex_clk or negedge ex_resetn) begin
    if (!ex_resetn) begin
      state_r      <= IDLE;
      cnt_r        <= 16'd0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'd0;
      load_pend_r  <= 1'b0;
      data_r       <= 8'd0;
      valid_r      <= 1'b0;
      cmd_r        <= 6'd0;
      cmd_en_r     <= 1'b0;
      frame_err_r  <= 1'b0;
      busy_r       <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      valid_r     <= 1'b0;
      cmd_en_r    <= 1'b0;
      frame_err_r <= 1'b0;
      load_pend_r <= 1'b0;

      // Byte accepted on the previous cycle: publish it one cycle after the
      // stop-bit sample. shift_r is stable here because the next frame's
      // first data bit is at least a bit period away.
      if (load_pend_r) begin
        data_r  <= shift_r;
        valid_r <= 1'b1;
        if (shift_r[7:6] == 2'b01) begin
          cmd_r    <= shift_r[5:0];
          cmd_en_r <= 1'b1;
        end
      end

      case (state_r)
        IDLE: begin
          if (!rx_sync_r) begin
            state_r   <= START;
            cnt_r     <= 16'd0;
            bit_idx_r <= 3'd0;
            busy_r    <= 1'b1;
          end
        end

        START: begin
          if (cnt_r == BIT_HALF) begin
            cnt_r <= 16'd0;
            if (!rx_sync_r) begin
              state_r <= DATA;
            end else begin
              // Line went back high: a glitch, not a start bit.
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r     <= 16'd0;
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
              state_r <= PARITY;
`else
              state_r <= STOP;
`endif
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

`ifdef UART_PARITY_EN
        PARITY: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r        <= 16'd0;
            parity_err_r <= (rx_sync_r != even_parity(shift_r));
            state_r      <= STOP;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
`endif

        STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r <= 16'd0;
            if (rx_sync_r) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              if (parity_bad_s) begin
                frame_err_r <= 1'b1;
              end else begin
                load_pend_r <= 1'b1;
              end
            end else begin
              // Low stop bit: framing error or break; wait for idle line.
              frame_err_r <= 1'b1;
              state_r     <= BREAK;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        BREAK: begin
          if (rx_sync_r) begin
            state_r <= IDLE;
            cnt_r   <= 16'd0;
            busy_r  <= 1'b0;
          end
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= 16'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed testbench for uart_cmd_rx with CLKS_PER_BIT = 8.
// Line stimulus changes on the falling clock edge; outputs are observed on
// the falling edge. Pulse monitors accumulate counts that the main sequence
// compares against hand-computed expectations.
module tb_uart_cmd_rx;

  localparam int CPB = 8;

  logic       ex_clk;
  logic       ex_resetn;
  logic       uart_rx;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid;
  logic [5:0] uart_cmd;
  logic       uart_cmd_en;
  logic       uart_frame_err;
  logic       uart_busy;

  int errors;
  int checks;

  int valid_cnt;
  int cmd_en_cnt;
  int ferr_cnt;
  int cmd_with_valid;
  logic [7:0] last_data;

  int v0, c0, f0, cv0;
  logic ok;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .ex_clk         (ex_clk),
    .ex_resetn      (ex_resetn),
    .uart_rx        (uart_rx),
    .uart_rx_data   (uart_rx_data),
    .uart_rx_valid  (uart_rx_valid),
    .uart_cmd       (uart_cmd),
    .uart_cmd_en    (uart_cmd_en),
    .uart_frame_err (uart_frame_err),
    .uart_busy      (uart_busy)
  );

  initial ex_clk = 1'b0;
  always #5 ex_clk = ~ex_clk;

  // Pulse monitors.
  always @(negedge ex_clk) begin
    if (ex_resetn) begin
      if (uart_rx_valid) begin
        valid_cnt = valid_cnt + 1;
        last_data = uart_rx_data;
        if (uart_cmd_en) cmd_with_valid = cmd_with_valid + 1;
      end
      if (uart_cmd_en)    cmd_en_cnt = cmd_en_cnt + 1;
      if (uart_frame_err) ferr_cnt = ferr_cnt + 1;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge ex_clk);
  endtask

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge ex_clk);
  endtask

  // Start bit, 8 data bits LSB first, and the parity bit when enabled.
  task automatic send_bits(input logic [7:0] b, input logic par_good);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_PARITY_EN
    bit_time(par_good ? ^b : ~^b);
`else
    if (!par_good) $display("note: parity request ignored in 8N1 build");
`endif
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_good);
    send_bits(b, par_good);
    bit_time(stop_bit);
  endtask

  task automatic snap();
    v0 = valid_cnt; c0 = cmd_en_cnt; f0 = ferr_cnt; cv0 = cmd_with_valid;
  endtask

  initial begin
    errors = 0; checks = 0;
    valid_cnt = 0; cmd_en_cnt = 0; ferr_cnt = 0; cmd_with_valid = 0;
    last_data = 8'h00;
    uart_rx = 1'b1;
    ex_resetn = 1'b0;
    repeat (3) @(negedge ex_clk);

    // Reset state.
    check("rst_data",  32'(uart_rx_data),   32'h00);
    check("rst_valid", 32'(uart_rx_valid),  32'h0);
    check("rst_cmd",   32'(uart_cmd),       32'h00);
    check("rst_cmd_en",32'(uart_cmd_en),    32'h0);
    check("rst_ferr",  32'(uart_frame_err), 32'h0);
    check("rst_busy",  32'(uart_busy),      32'h0);
    ex_resetn = 1'b1;
    idle(10);

    // 0x45: command byte, cmd = 0x05.
    snap();
    send_frame(8'h45, 1'b1, 1'b1);
    idle(6);
    check("f45_valid_cnt", 32'(valid_cnt - v0),       32'd1);
    check("f45_data",      32'(last_data),            32'h45);
    check("f45_cmd_same",  32'(cmd_with_valid - cv0), 32'd1);
    check("f45_cmd",       32'(uart_cmd),             32'h05);
    check("f45_ferr",      32'(ferr_cnt - f0),        32'd0);
    check("f45_busy",      32'(uart_busy),            32'h0);

    // 0xA3: data byte only; command held.
    snap();
    send_frame(8'hA3, 1'b1, 1'b1);
    idle(6);
    check("fA3_valid_cnt", 32'(valid_cnt - v0),  32'd1);
    check("fA3_data",      32'(uart_rx_data),    32'hA3);
    check("fA3_cmd_en",    32'(cmd_en_cnt - c0), 32'd0);
    check("fA3_cmd_hold",  32'(uart_cmd),        32'h05);

    // 0x55 with low stop bit, line low 20 cycles: frame error and break.
    snap();
    send_bits(8'h55, 1'b1);
    uart_rx = 1'b0;
    repeat (20) @(negedge ex_clk);
    check("brk_busy_high", 32'(uart_busy),       32'h1);
    check("brk_ferr",      32'(ferr_cnt - f0),   32'd1);
    check("brk_no_valid",  32'(valid_cnt - v0),  32'd0);
    check("brk_data_hold", 32'(uart_rx_data),    32'hA3);
    uart_rx = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ex_clk);
      if (!uart_busy) begin ok = 1'b1; break; end
    end
    check("brk_busy_release", 32'(ok), 32'h1);
    idle(4);
    snap();
    send_frame(8'h41, 1'b1, 1'b1);
    idle(6);
    check("f41_data", 32'(uart_rx_data), 32'h41);
    check("f41_cmd",  32'(uart_cmd),     32'h01);

    // Two-cycle low glitch: rejected, busy drops within 6 cycles.
    snap();
    uart_rx = 1'b0;
    repeat (2) @(negedge ex_clk);
    uart_rx = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ex_clk);
      if (!uart_busy) begin ok = 1'b1; break; end
    end
    check("glitch_busy_low", 32'(ok), 32'h1);
    idle(10);
    check("glitch_no_pulses", 32'((valid_cnt - v0) + (cmd_en_cnt - c0) + (ferr_cnt - f0)), 32'd0);

    // Back-to-back frames, one stop bit each.
    snap();
    send_frame(8'h4A, 1'b1, 1'b1);
    send_frame(8'h12, 1'b1, 1'b1);
    idle(6);
    check("b2b_valid_cnt", 32'(valid_cnt - v0),  32'd2);
    check("b2b_cmd_en",    32'(cmd_en_cnt - c0), 32'd1);
    check("b2b_data",      32'(uart_rx_data),    32'h12);
    check("b2b_cmd",       32'(uart_cmd),        32'h0A);

    // Reset during data bit 4 of 0x7E.
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(((8'h7E >> i) & 8'h01) != 8'h00);
    uart_rx = 1'b1;  // bit 4 of 0x7E
    repeat (4) @(negedge ex_clk);
    check("mid_busy_high", 32'(uart_busy), 32'h1);
    ex_resetn = 1'b0;
    @(negedge ex_clk);
    check("mid_rst_outputs",
          32'({uart_rx_data, uart_rx_valid, uart_cmd, uart_cmd_en, uart_frame_err, uart_busy}),
          32'h0);
    repeat (3) @(negedge ex_clk);
    ex_resetn = 1'b1;
    idle(12);
    snap();
    send_frame(8'h7E, 1'b1, 1'b1);
    idle(6);
    check("f7E_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("f7E_data",      32'(uart_rx_data),   32'h7E);
    check("f7E_cmd",       32'(uart_cmd),       32'h3E);

`ifdef UART_PARITY_EN
    // 0x43 has three ones: correct even parity bit is 1.
    snap();
    send_frame(8'h43, 1'b1, 1'b0);
    idle(6);
    check("par_bad_ferr",     32'(ferr_cnt - f0),  32'd1);
    check("par_bad_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("par_bad_cmd_hold", 32'(uart_cmd),       32'h3E);
    check("par_bad_busy",     32'(uart_busy),      32'h0);
    snap();
    send_frame(8'h43, 1'b1, 1'b1);
    idle(6);
    check("par_ok_valid", 32'(valid_cnt - v0), 32'd1);
    check("par_ok_data",  32'(uart_rx_data),   32'h43);
    check("par_ok_cmd",   32'(uart_cmd),       32'h03);
    check("par_ok_ferr",  32'(ferr_cnt - f0),  32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, ex_clk cycles per UART bit (434 = 50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port ex_clk, input, 1, sole clock; all logic is on the rising edge.
REQ-003 SHALL have port ex_resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port uart_rx, input, 1, asynchronous serial line; idles high.
REQ-005 SHALL have port uart_rx_data, output, 8, last correctly received byte.
REQ-006 SHALL have port uart_rx_valid, output, 1, one-cycle pulse when uart_rx_data updates.
REQ-007 SHALL have port uart_cmd, output, 6, host command index from the last command byte.
REQ-008 SHALL have port uart_cmd_en, output, 1, one-cycle pulse when uart_cmd updates.
REQ-009 SHALL have port uart_frame_err, output, 1, one-cycle pulse on a bad stop bit (or a bad parity bit, per REQ-024).
REQ-010 SHALL have port uart_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 SHALL pass uart_rx through a 2-flop synchronizer; both flops reset to 1; all decisions use the synchronizer output.
REQ-012 SHALL implement states IDLE, START, DATA, STOP and BREAK, plus PARITY when REQ-024 applies.
REQ-013 IDLE: a synchronized low SHALL move the FSM to START and clear the bit counter.
REQ-014 START: at count CLKS_PER_BIT/2 (integer division), the FSM SHALL go to DATA if the line is low, else return to IDLE with no error (glitch rejection).
REQ-015 DATA: the FSM SHALL sample every CLKS_PER_BIT cycles and shift 8 bits LSB first, then enter STOP (or PARITY).
REQ-016 STOP: after CLKS_PER_BIT cycles, a sampled 1 SHALL load uart_rx_data and pulse uart_rx_valid on the next cycle, then return to IDLE.
REQ-017 STOP: a sampled 0 SHALL pulse uart_frame_err, leave uart_rx_data unchanged, give no valid pulse, and enter BREAK.
REQ-018 BREAK: the FSM SHALL stay until the synchronized line is high, then go to IDLE.
REQ-019 On uart_rx_valid, if byte[7:6]==2'b01, the block SHALL load uart_cmd=byte[5:0] and pulse uart_cmd_en in the same cycle as uart_rx_valid; other bytes SHALL leave uart_cmd unchanged.
REQ-020 uart_rx_data and uart_cmd SHALL hold their values between updates.
REQ-021 The bit-period counter SHALL be 16 bits wide and reset to 0 on every state transition.
REQ-022 Latency from the stop-bit sample to uart_rx_valid SHALL be exactly 1 ex_clk cycle; back-to-back frames with a one-bit stop SHALL be received without loss.

Reset
REQ-023 On ex_resetn low, state=IDLE, counters=0, shift register=0, uart_rx_data=0, uart_cmd=0, all pulse outputs=0, uart_busy=0, even mid-frame; after release, the FSM SHALL wait for a fresh start edge.

Configuration
REQ-024 With macro UART_PARITY_EN defined, one even-parity bit SHALL follow the data bits in state PARITY; a mismatch SHALL pulse uart_frame_err at the stop-bit sample, drop the byte, and return to IDLE if the stop bit is 1 or enter BREAK if it is 0.
REQ-025 Without UART_PARITY_EN, frames SHALL be 8N1 and the PARITY state and logic SHALL not exist.

Verification (CLKS_PER_BIT=8)
REQ-026 Frame 0x45, 8N1 -> one uart_rx_valid with uart_rx_data=0x45; same cycle uart_cmd_en with uart_cmd=0x05.
REQ-027 Frame 0xA3 -> uart_rx_valid with data 0xA3; no uart_cmd_en; uart_cmd keeps its prior value.
REQ-028 Frame 0x55 with stop bit 0, line held low 20 cycles -> uart_frame_err pulse, no valid, uart_busy high until line high; next 0x41 frame -> uart_cmd=0x01.
REQ-029 Low glitch of 2 cycles -> no pulses; uart_busy returns low within 6 cycles.
REQ-030 ex_resetn low during data bit 4 of 0x7E -> all outputs 0; the following frame 0x7E is received correctly.
REQ-031 With UART_PARITY_EN, frame 0x43 with parity bit 0 (wrong) -> uart_frame_err pulse, no valid; with parity bit 1 -> valid with data 0x43 and uart_cmd=0x03.
